// File: rtl/cpu_program_loader.sv
// cpu_program_loader: streams a program image into the core's instruction and
// data memories, then releases the core from reset and runs it for a
// programmed number of cycles before reporting done.
module cpu_program_loader #(
   parameter int IMEM_DEPTH = 512,
   parameter int DMEM_DEPTH = 1024,
   parameter int RUN_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [9:0]       n_instr,
   input  logic [10:0]      n_dwords,
   input  logic [RUN_W-1:0] run_cycles,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   output logic [63:0]      addr_ext,
   output logic             wen_ext,
   output logic             ren_ext,
   output logic [31:0]      wdata_ext,
   output logic [63:0]      addr_ext_2,
   output logic             wen_ext_2,
   output logic             ren_ext_2,
   output logic [63:0]      wdata_ext_2,
   output logic             cpu_arst_n,
   output logic             cpu_enable,
   output logic             busy,
   output logic             done,
   output logic             err_len
);

   // Largest legal counts, sized to the count ports.
   localparam logic [9:0]  IMEM_MAX = 10'(IMEM_DEPTH);
   localparam logic [10:0] DMEM_MAX = 11'(DMEM_DEPTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_I  = 3'd1,
      LOAD_LO = 3'd2,
      LOAD_HI = 3'd3,
      PREP    = 3'd4,
      RUN     = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t           state_reg, state_next;

   // Counts latched at an accepted start.
   logic [9:0]       n_instr_reg, n_instr_next;
   logic [10:0]      n_dwords_reg, n_dwords_next;
   logic [RUN_W-1:0] run_cycles_reg, run_cycles_next;

   // Progress counters.
   logic [9:0]       instr_cnt_reg, instr_cnt_next;
   logic [10:0]      dword_cnt_reg, dword_cnt_next;
   logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;

   // Low half of the doubleword being assembled.
   logic [31:0]      lo_word_reg, lo_word_next;

   // Registered memory-write ports (one cycle after the accepting edge).
   logic [63:0]      addr_ext_reg, addr_ext_next;
   logic             wen_ext_reg, wen_ext_next;
   logic [31:0]      wdata_ext_reg, wdata_ext_next;
   logic [63:0]      addr_ext_2_reg, addr_ext_2_next;
   logic             wen_ext_2_reg, wen_ext_2_next;
   logic [63:0]      wdata_ext_2_reg, wdata_ext_2_next;
   logic             err_len_reg, err_len_next;

   logic             beat;
   logic             idle_or_done;
   logic             counts_ok;

   assign idle_or_done = (state_reg == IDLE) || (state_reg == DONE);
   assign counts_ok    = (n_instr <= IMEM_MAX) && (n_dwords <= DMEM_MAX);
   assign beat         = s_valid && s_ready;

   // Output decodes: all purely from registered state.
   assign s_ready     = (state_reg == LOAD_I) || (state_reg == LOAD_LO) || (state_reg == LOAD_HI);
   assign busy        = !idle_or_done;
   assign done        = (state_reg == DONE);
   assign cpu_enable  = (state_reg == RUN);
   // Core is held in reset while idle or loading; released from PREP onward.
   assign cpu_arst_n  = (state_reg == PREP) || (state_reg == RUN) || (state_reg == DONE);
   assign ren_ext     = 1'b0;
   assign ren_ext_2   = 1'b0;
   assign addr_ext    = addr_ext_reg;
   assign wen_ext     = wen_ext_reg;
   assign wdata_ext   = wdata_ext_reg;
   assign addr_ext_2  = addr_ext_2_reg;
   assign wen_ext_2   = wen_ext_2_reg;
   assign wdata_ext_2 = wdata_ext_2_reg;
   assign err_len     = err_len_reg;

   // Next-state and datapath: defaults hold everything, strobes return to 0.
   always_comb begin
      state_next       = state_reg;
      n_instr_next     = n_instr_reg;
      n_dwords_next    = n_dwords_reg;
      run_cycles_next  = run_cycles_reg;
      instr_cnt_next   = instr_cnt_reg;
      dword_cnt_next   = dword_cnt_reg;
      run_cnt_next     = run_cnt_reg;
      lo_word_next     = lo_word_reg;
      addr_ext_next    = addr_ext_reg;
      wen_ext_next     = 1'b0;
      wdata_ext_next   = wdata_ext_reg;
      addr_ext_2_next  = addr_ext_2_reg;
      wen_ext_2_next   = 1'b0;
      wdata_ext_2_next = wdata_ext_2_reg;
      err_len_next     = 1'b0;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               if (!counts_ok) begin
                  // Reject: report and leave state and latched counts alone.
                  err_len_next = 1'b1;
               end else begin
                  n_instr_next    = n_instr;
                  n_dwords_next   = n_dwords;
                  run_cycles_next = run_cycles;
                  instr_cnt_next  = '0;
                  dword_cnt_next  = '0;
                  run_cnt_next    = '0;
                  if (n_instr != 10'd0)
                     state_next = LOAD_I;
                  else if (n_dwords != 11'd0)
                     state_next = LOAD_LO;
                  else
                     state_next = PREP;
               end
            end
         end

         LOAD_I: begin
            if (beat) begin
               wen_ext_next   = 1'b1;
               wdata_ext_next = s_data;
               addr_ext_next  = {52'd0, instr_cnt_reg, 2'b00};
               instr_cnt_next = instr_cnt_reg + 10'd1;
               if (instr_cnt_reg == n_instr_reg - 10'd1)
                  state_next = (n_dwords_reg != 11'd0) ? LOAD_LO : PREP;
            end
         end

         LOAD_LO: begin
            if (beat) begin
               lo_word_next = s_data;
               state_next   = LOAD_HI;
            end
         end

         LOAD_HI: begin
            if (beat) begin
               wen_ext_2_next   = 1'b1;
               wdata_ext_2_next = {s_data, lo_word_reg};
               addr_ext_2_next  = {50'd0, dword_cnt_reg, 3'b000};
               dword_cnt_next   = dword_cnt_reg + 11'd1;
               if (dword_cnt_reg == n_dwords_reg - 11'd1)
                  state_next = PREP;
               else
                  state_next = LOAD_LO;
            end
         end

         PREP: begin
            // Single release cycle; the last write lands here.
            run_cnt_next = '0;
            state_next   = (run_cycles_reg == '0) ? DONE : RUN;
         end

         RUN: begin
            if (run_cnt_reg == run_cycles_reg - 1'b1)
               state_next = DONE;
            else
               run_cnt_next = run_cnt_reg + 1'b1;
         end

         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset; reset drops any pending strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         n_instr_reg     <= '0;
         n_dwords_reg    <= '0;
         run_cycles_reg  <= '0;
         instr_cnt_reg   <= '0;
         dword_cnt_reg   <= '0;
         run_cnt_reg     <= '0;
         lo_word_reg     <= '0;
         addr_ext_reg    <= '0;
         wen_ext_reg     <= 1'b0;
         wdata_ext_reg   <= '0;
         addr_ext_2_reg  <= '0;
         wen_ext_2_reg   <= 1'b0;
         wdata_ext_2_reg <= '0;
         err_len_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         n_instr_reg     <= n_instr_next;
         n_dwords_reg    <= n_dwords_next;
         run_cycles_reg  <= run_cycles_next;
         instr_cnt_reg   <= instr_cnt_next;
         dword_cnt_reg   <= dword_cnt_next;
         run_cnt_reg     <= run_cnt_next;
         lo_word_reg     <= lo_word_next;
         addr_ext_reg    <= addr_ext_next;
         wen_ext_reg     <= wen_ext_next;
         wdata_ext_reg   <= wdata_ext_next;
         addr_ext_2_reg  <= addr_ext_2_next;
         wen_ext_2_reg   <= wen_ext_2_next;
         wdata_ext_2_reg <= wdata_ext_2_next;
         err_len_reg     <= err_len_next;
      end
   end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed testbench for cpu_program_loader.
module tb_cpu_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  n_instr;
   logic [10:0] n_dwords;
   logic [31:0] run_cycles;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_arst_n;
   logic        cpu_enable;
   logic        busy;
   logic        done;
   logic        err_len;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Write logs and enable-cycle counter filled by the monitor.
   logic [63:0] i_addr_q[$];
   logic [31:0] i_data_q[$];
   logic [63:0] d_addr_q[$];
   logic [63:0] d_data_q[$];
   int          en_cycles = 0;
   int          err_pulses = 0;

   always #5 clk = ~clk;

   cpu_program_loader dut (
      .clk(clk), .rst(rst), .start(start), .n_instr(n_instr), .n_dwords(n_dwords),
      .run_cycles(run_cycles), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
      .busy(busy), .done(done), .err_len(err_len)
   );

   // Monitor samples on the falling edge, one line per write.
   always @(negedge clk) begin
      if (wen_ext) begin
         i_addr_q.push_back(addr_ext);
         i_data_q.push_back(wdata_ext);
         $display("imem write addr=%0h data=%08h", addr_ext, wdata_ext);
      end
      if (wen_ext_2) begin
         d_addr_q.push_back(addr_ext_2);
         d_data_q.push_back(wdata_ext_2);
         $display("dmem write addr=%0h data=%016h", addr_ext_2, wdata_ext_2);
      end
      if (cpu_enable) en_cycles++;
      if (err_len) err_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      i_addr_q.delete(); i_data_q.delete();
      d_addr_q.delete(); d_data_q.delete();
      en_cycles = 0;
      err_pulses = 0;
   endtask

   task automatic do_start(input int ni, input int nd, input int rc);
      start = 1'b1;
      n_instr = 10'(ni);
      n_dwords = 11'(nd);
      run_cycles = 32'(rc);
      tick();
      start = 1'b0;
      $display("start n_instr=%0d n_dwords=%0d run_cycles=%0d", ni, nd, rc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Present one word until accepted, bounded.
   task automatic feed_word(input logic [31:0] w);
      int n;
      s_valid = 1'b1;
      s_data = w;
      n = 0;
      while (!s_ready && n < 20) begin
         tick();
         n++;
      end
      total_cnt++;
      if (!s_ready) $display("FAIL feed_timeout word=%08h s_ready=%0b required=1", w, s_ready);
      else pass_cnt++;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      while (!done && n < bound) begin
         tick();
         n++;
      end
      total_cnt++;
      if (done !== 1'b1) $display("FAIL wait_done done=%0b required=1", done);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({s_ready, wen_ext, wen_ext_2, ren_ext, ren_ext_2, cpu_arst_n, cpu_enable, busy, done, err_len} !== 10'b0)
         $display("FAIL reset_ctrl got=%b required=0000000000",
                  {s_ready, wen_ext, wen_ext_2, ren_ext, ren_ext_2, cpu_arst_n, cpu_enable, busy, done, err_len});
      else pass_cnt++;
      total_cnt++;
      if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2} !== 224'd0)
         $display("FAIL reset_data got=%h required=0", {addr_ext, wdata_ext, addr_ext_2, wdata_ext_2});
      else pass_cnt++;
   endtask

   task automatic test_basic_load();
      logic [31:0] words[7];
      words = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77};
      clear_logs();
      do_start(3, 2, 5);
      total_cnt++;
      if (cpu_arst_n !== 1'b0 || busy !== 1'b1)
         $display("FAIL basic_loading arst_n=%0b busy=%0b required 0/1", cpu_arst_n, busy);
      else pass_cnt++;
      for (int i = 0; i < 7; i++) feed_word(words[i]);
      // Now in PREP: final write visible, core released, enable still low.
      total_cnt++;
      if (wen_ext_2 !== 1'b1 || cpu_enable !== 1'b0 || cpu_arst_n !== 1'b1 || s_ready !== 1'b0)
         $display("FAIL basic_prep wen2=%0b en=%0b arst_n=%0b rdy=%0b required 1/0/1/0",
                  wen_ext_2, cpu_enable, cpu_arst_n, s_ready);
      else pass_cnt++;
      // An extra word must not be taken.
      s_valid = 1'b1;
      s_data = 32'h88;
      wait_done(40);
      s_valid = 1'b0;
      total_cnt++;
      if (i_addr_q.size() !== 3 || i_addr_q[0] !== 64'd0 || i_addr_q[1] !== 64'd4 || i_addr_q[2] !== 64'd8 ||
          i_data_q[0] !== 32'h11 || i_data_q[1] !== 32'h22 || i_data_q[2] !== 32'h33)
         $display("FAIL basic_imem count=%0d required 3 writes 11@0 22@4 33@8", i_addr_q.size());
      else pass_cnt++;
      total_cnt++;
      if (d_addr_q.size() !== 2 || d_addr_q[0] !== 64'd0 || d_addr_q[1] !== 64'd8 ||
          d_data_q[0] !== 64'h0000005500000044 || d_data_q[1] !== 64'h0000007700000066)
         $display("FAIL basic_dmem count=%0d required 2 writes 5500000044@0 7700000066@8", d_addr_q.size());
      else pass_cnt++;
      total_cnt++;
      if (en_cycles !== 5) $display("FAIL basic_enable got=%0d required=5", en_cycles);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0 || cpu_arst_n !== 1'b1 || cpu_enable !== 1'b0)
         $display("FAIL basic_done busy=%0b arst_n=%0b en=%0b required 0/1/0", busy, cpu_arst_n, cpu_enable);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      int idx;
      logic acc;
      clear_logs();
      do_start(4, 0, 1);
      idx = 0;
      for (int c = 0; c < 40 && idx < 4; c++) begin
         s_valid = (c % 2 == 0);
         s_data = 32'h100 + 32'(idx);
         acc = s_valid && s_ready;
         tick();
         total_cnt++;
         if (wen_ext !== acc) $display("FAIL stall_wen cycle=%0d got=%0b required=%0b", c, wen_ext, acc);
         else pass_cnt++;
         if (acc) idx++;
      end
      s_valid = 1'b0;
      wait_done(20);
      total_cnt++;
      if (i_addr_q.size() !== 4 || i_addr_q[0] !== 64'd0 || i_addr_q[1] !== 64'd4 ||
          i_addr_q[2] !== 64'd8 || i_addr_q[3] !== 64'd12 || i_data_q[3] !== 32'h103)
         $display("FAIL stall_imem count=%0d required 4 contiguous writes", i_addr_q.size());
      else pass_cnt++;
      total_cnt++;
      if (en_cycles !== 1) $display("FAIL stall_enable got=%0d required=1", en_cycles);
      else pass_cnt++;
   endtask

   task automatic test_err_len();
      do_reset();
      clear_logs();
      do_start(513, 0, 3);
      total_cnt++;
      if (err_len !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL err_pulse err=%0b rdy=%0b busy=%0b done=%0b required 1/0/0/0", err_len, s_ready, busy, done);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (err_len !== 1'b0 || err_pulses !== 1 || s_ready !== 1'b0)
         $display("FAIL err_single err=%0b pulses=%0d rdy=%0b required 0/1/0", err_len, err_pulses, s_ready);
      else pass_cnt++;
      do_start(0, 1025, 3);
      total_cnt++;
      if (err_len !== 1'b1 || busy !== 1'b0)
         $display("FAIL err_dwords err=%0b busy=%0b required 1/0", err_len, busy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (i_addr_q.size() + d_addr_q.size() !== 0 || busy !== 1'b0)
         $display("FAIL err_nowrite writes=%0d busy=%0b required 0/0", i_addr_q.size() + d_addr_q.size(), busy);
      else pass_cnt++;
   endtask

   task automatic test_empty();
      clear_logs();
      do_start(0, 0, 0);
      total_cnt++;
      if (busy !== 1'b1 || cpu_arst_n !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0)
         $display("FAIL empty_prep busy=%0b arst_n=%0b rdy=%0b done=%0b required 1/1/0/0", busy, cpu_arst_n, s_ready, done);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL empty_done done=%0b busy=%0b required 1/0", done, busy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (en_cycles !== 0 || i_addr_q.size() + d_addr_q.size() !== 0)
         $display("FAIL empty_quiet en=%0d writes=%0d required 0/0", en_cycles, i_addr_q.size() + d_addr_q.size());
      else pass_cnt++;
   endtask

   task automatic test_rst_mid();
      clear_logs();
      do_start(1, 2, 3);
      feed_word(32'hA1);
      feed_word(32'hB0);
      total_cnt++;
      if (s_ready !== 1'b1 || busy !== 1'b1)
         $display("FAIL rstmid_hi rdy=%0b busy=%0b required 1/1", s_ready, busy);
      else pass_cnt++;
      s_valid = 1'b1;
      s_data = 32'hB1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      s_valid = 1'b0;
      total_cnt++;
      if ({s_ready, wen_ext, wen_ext_2, cpu_arst_n, cpu_enable, busy, done, err_len} !== 8'b0)
         $display("FAIL rstmid_outputs got=%b required=00000000",
                  {s_ready, wen_ext, wen_ext_2, cpu_arst_n, cpu_enable, busy, done, err_len});
      else pass_cnt++;
      tick();
      total_cnt++;
      if (d_addr_q.size() !== 0) $display("FAIL rstmid_nowrite got=%0d required=0", d_addr_q.size());
      else pass_cnt++;
      clear_logs();
      do_start(0, 1, 1);
      feed_word(32'hC0);
      feed_word(32'hC1);
      wait_done(20);
      total_cnt++;
      if (d_addr_q.size() !== 1 || d_addr_q[0] !== 64'd0 || d_data_q[0] !== 64'h000000C1000000C0)
         $display("FAIL rstmid_restart count=%0d required 1 write 000000C1000000C0@0", d_addr_q.size());
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      clear_logs();
      do_start(1, 0, 6);
      feed_word(32'hD0);
      tick();
      total_cnt++;
      if (cpu_enable !== 1'b1) $display("FAIL b2b_run en=%0b required=1", cpu_enable);
      else pass_cnt++;
      do_start(0, 0, 2);
      total_cnt++;
      if (busy !== 1'b1 || err_len !== 1'b0)
         $display("FAIL b2b_ignore busy=%0b err=%0b required 1/0", busy, err_len);
      else pass_cnt++;
      wait_done(30);
      total_cnt++;
      if (en_cycles !== 6) $display("FAIL b2b_runlen got=%0d required=6", en_cycles);
      else pass_cnt++;
      clear_logs();
      do_start(0, 0, 1);
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b1 || cpu_arst_n !== 1'b1)
         $display("FAIL b2b_restart done=%0b busy=%0b arst_n=%0b required 0/1/1", done, busy, cpu_arst_n);
      else pass_cnt++;
      wait_done(10);
      total_cnt++;
      if (en_cycles !== 1) $display("FAIL b2b_second got=%0d required=1", en_cycles);
      else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      n_instr = '0;
      n_dwords = '0;
      run_cycles = '0;
      s_valid = 1'b0;
      s_data = '0;
      test_reset();
      test_basic_load();
      test_stall();
      test_err_len();
      test_empty();
      test_rst_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
